ifid_fetch_stage: RTL
=====================

# ifid_fetch_stage

Instruction-fetch stage and IF/ID pipeline register for the 5-stage MIPS pipeline; sits directly upstream of the hazard unit and decode stage. Owns the PC, issues requests to a variable-latency instruction memory, and loads IF/ID. Obeys the hazard unit's `PCWrite`/`IFIDWrite` stall controls and the EX-stage branch redirect. A one-entry skid buffer holds an instruction returned during a stall.

## Interface
- `RESET_PC`, 32'h0000_0000, PC value after reset
- `NOP`, 32'h0000_0000, instruction word inserted as a bubble
- `clk` in 1: rising-edge clock
- `rst` in 1: synchronous reset, active-high
- `PCWrite` in 1: from hazard unit; 0 = hold PC
- `IFIDWrite` in 1: from hazard unit; 0 = hold IF/ID
- `BranchTaken` in 1: redirect and flush request
- `BranchTarget` in 32: redirect address
- `imem_req` out 1: fetch request
- `imem_addr` out 32: fetch address
- `imem_ready` in 1: response valid, same cycle as accepted request
- `imem_rdata` in 32: instruction word
- `PC` out 32: current fetch PC
- `IFID_Instr` out 32: instruction to decode
- `IFID_PC4` out 32: fetch PC + 4 of `IFID_Instr`
- `IFID_Valid` out 1: 0 = bubble

## Operation
- Define `adv = PCWrite & IFIDWrite`. Any other combination is a stall; PC is not written.
- FSM states: FETCH (`imem_req`=1, `imem_addr`=PC), HOLD (`imem_req`=0; skid buffer full), DROP (`imem_req`=1, `imem_addr`=latched stale address; response discarded).
- `imem_req`/`imem_addr` are decoded combinationally from state. Memory protocol: request and address held stable until `imem_ready`.
- `BranchTaken` has top priority in every state:
  - PC <= `BranchTarget`, IF/ID <= {`NOP`, PC4 0, Valid 0}, skid buffer cleared.
  - The flush overrides `IFIDWrite`=0.
  - From FETCH with `imem_ready`=0: latch the current PC as the drop address and go to DROP.
  - From FETCH with `imem_ready`=1: stay in FETCH and discard the data.
  - From HOLD: go to FETCH.
  - From DROP: stay in DROP with the drop address unchanged.
- FETCH, `imem_ready`=1:
  - If `adv`: IF/ID <= {`imem_rdata`, PC+4, 1} and PC <= PC+4.
  - Otherwise: buffer `imem_rdata` and PC+4, then go to HOLD.
- FETCH, `imem_ready`=0:
  - If `IFIDWrite`: IF/ID <= bubble.
  - Otherwise: hold IF/ID.
  - PC unchanged.
- HOLD:
  - If `adv`: IF/ID <= buffer with Valid 1, PC <= PC+4, go to FETCH.
  - Otherwise: hold everything.
- DROP:
  - On `imem_ready`: go to FETCH; the data is never written anywhere.
  - While in DROP, if `IFIDWrite`: IF/ID <= bubble.
- Arithmetic: PC+4 is 32-bit unsigned and wraps modulo 2^32; 32'hFFFF_FFFC + 4 = 0.
- No alignment check; `BranchTarget` bits [1:0] are passed through unchanged.

## Timing
- Reset, checked at the edge where `rst`=1:
  - state FETCH, PC=`RESET_PC`, `IFID_Instr`=`NOP`, `IFID_PC4`=0, `IFID_Valid`=0, skid buffer empty.
  - Consequently `imem_req`=1 and `imem_addr`=`RESET_PC` from the first cycle after reset.
- `rst` mid-operation discards any outstanding request. The instruction memory shares `rst`.
- Zero-wait memory (`imem_ready`=1 each cycle) with `adv`=1: one instruction per cycle. Latency from the fetch-request cycle to IF/ID visible is 1 cycle.
- Stall release from HOLD: the buffered instruction appears in IF/ID on the first edge with `adv`=1. The next fetch request is issued in the following cycle, so there is one request-free cycle.
- Taken branch: IF/ID shows a bubble the cycle after `BranchTaken`. The first request to the target is issued in the following cycle (FETCH), or after the stale response is received (DROP).
- Simultaneous `BranchTaken` and stall: the branch wins.
- Simultaneous `imem_ready` and `BranchTaken` in FETCH: the data is discarded.

## Test plan
- Reset then zero-wait memory returning addr+32'h100, `adv`=1: IF/ID gets (0x100, PC4 4, V1), then (0x104, 8, V1), then (0x108, 12, V1) on consecutive cycles; PC=4,8,12.
- Stall: `adv`=0 for 3 cycles while PC=8 and memory is ready:
  - FSM enters HOLD; `imem_req`=0 for 3 cycles; PC stays 8; IF/ID held.
  - On release, IF/ID=(0x108, 12, V1); the next request goes to 12.
- Wait states: `imem_ready` low for 2 cycles with `IFIDWrite`=1: two bubbles (V0, `NOP`); `imem_addr` stable; the instruction then loads with V1.
- Branch during outstanding request:
  - PC=0x20 not ready; `BranchTaken`, target 0x400.
  - Expected: state DROP, `imem_addr`=0x20 until ready, data discarded. Then a request to 0x400; IF/ID V0 until 0x400's instruction arrives.
- Branch with `IFIDWrite`=0 while in HOLD: IF/ID flushed to V0 regardless; PC=target; state FETCH.
- PC wrap: `BranchTaken` target 32'hFFFF_FFFC, then one fetch: `IFID_PC4`=0, PC=0.

Source files
------------

// File: rtl/ifid_fetch_stage.sv
// ifid_fetch_stage: MIPS fetch stage with PC, variable-latency imem handshake, one-entry skid buffer and IF/ID register
module ifid_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        PCWrite,
  input  logic        IFIDWrite,
  input  logic        BranchTaken,
  input  logic [31:0] BranchTarget,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] PC,
  output logic [31:0] IFID_Instr,
  output logic [31:0] IFID_PC4,
  output logic        IFID_Valid
);
  typedef enum logic [1:0] {FETCH, HOLD, DROP} state_t;
  state_t state_q, state_d;
  logic [31:0] pc_q, pc_d, drop_q, drop_d, buf_instr_q, buf_instr_d, buf_pc4_q, buf_pc4_d;
  logic [31:0] instr_q, instr_d, pc4_q, pc4_d;
  logic        valid_q, valid_d;
  logic [31:0] pc_inc;
  logic        adv;
  assign adv = PCWrite & IFIDWrite;
  assign pc_inc = pc_q + 32'd4;
  assign imem_req = state_q != HOLD;
  assign imem_addr = state_q == DROP ? drop_q : pc_q;
  assign PC = pc_q;
  assign IFID_Instr = instr_q;
  assign IFID_PC4 = pc4_q;
  assign IFID_Valid = valid_q;
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    drop_d = drop_q;
    buf_instr_d = buf_instr_q;
    buf_pc4_d = buf_pc4_q;
    instr_d = instr_q;
    pc4_d = pc4_q;
    valid_d = valid_q;
    if (BranchTaken) begin
      pc_d = BranchTarget;
      instr_d = NOP;
      pc4_d = '0;
      valid_d = 1'b0;
      buf_instr_d = '0;
      buf_pc4_d = '0;
      state_d = (state_q == FETCH && !imem_ready) ? DROP : (state_q == HOLD ? FETCH : state_q);
      drop_d = (state_q == FETCH && !imem_ready) ? pc_q : drop_q;
    end else if (state_q == FETCH && imem_ready) begin
      if (adv) begin
        instr_d = imem_rdata;
        pc4_d = pc_inc;
        valid_d = 1'b1;
        pc_d = pc_inc;
      end else begin
        buf_instr_d = imem_rdata;
        buf_pc4_d = pc_inc;
        state_d = HOLD;
      end
    end else if (state_q == HOLD) begin
      if (adv) begin
        instr_d = buf_instr_q;
        pc4_d = buf_pc4_q;
        valid_d = 1'b1;
        pc_d = pc_inc;
        state_d = FETCH;
      end
    end else begin
      if (IFIDWrite) begin
        instr_d = NOP;
        pc4_d = '0;
        valid_d = 1'b0;
      end
      if (state_q == DROP && imem_ready) state_d = FETCH;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH;
      pc_q <= RESET_PC;
      drop_q <= '0;
      buf_instr_q <= '0;
      buf_pc4_q <= '0;
      instr_q <= NOP;
      pc4_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      drop_q <= drop_d;
      buf_instr_q <= buf_instr_d;
      buf_pc4_q <= buf_pc4_d;
      instr_q <= instr_d;
      pc4_q <= pc4_d;
      valid_q <= valid_d;
    end
  end
endmodule
